btb_assoc: RTL and testbench
============================

Name: btb_assoc

Overview:
- Set-associative branch target buffer for the PC generation stage.
- Generalises the direct-mapped BTB with configurable sets, ways, tag width, counter width and instruction offset.
- Adds per-set round-robin replacement and a multi-cycle sweeping flush.
- The stage looks up the current fetch PC combinationally. The resolved-branch path updates the BTB on the next clock edge.

Parameters:
NR_SETS, 64, number of sets (power of 2, >=2)
NR_WAYS, 2, ways per set (power of 2, >=1)
CNT_BITS, 2, saturating counter width (>=1)
TAG_BITS, 8, stored PC tag bits
VLEN, 64, address width
OFFSET, 1, low PC bits excluded from indexing

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  start a full invalidate sweep
busy_o  out  1  flush sweep in progress
lookup_pc_i  in  VLEN  fetch PC to predict
lookup_valid_o  out  1  hit in a valid way
lookup_taken_o  out  1  MSB of hit counter
lookup_target_o  out  VLEN  hit target address
lookup_is_lower_16_o  out  1  hit branch sits in lower 16 bits of fetch word
update_valid_i  in  1  resolved branch update
update_pc_i  in  VLEN  PC of resolved branch
update_target_i  in  VLEN  resolved target
update_taken_i  in  1  branch outcome
update_is_lower_16_i  in  1  compressed/lower-half flag
update_clear_i  in  1  invalidate entry (aliasing, not a branch)

Behaviour:
- Index = pc[OFFSET+log2(NR_SETS)-1:OFFSET]. Tag = next TAG_BITS bits above the index.
- Each entry holds valid, tag, target, counter and is_lower_16. Each set holds a round-robin pointer of log2(NR_WAYS) bits (no pointer when NR_WAYS=1).

Lookup (combinational on registered state):
- Hit = valid && tag match. With multiple matches, the lowest way wins.
- On a miss, or while busy_o=1, all lookup_* outputs are 0.

Update (effective at the next edge, visible to lookup the following cycle):
- Lookup and update to the same entry in the same cycle: lookup returns the old contents.
- Hit, clear=1: valid<=0. Nothing else changes.
- Hit, clear=0:
  - Target and is_lower_16 are overwritten.
  - Counter +1 if taken, -1 if not taken, saturating at 0 and 2^CNT_BITS-1.
- Miss, clear=1: no change.
- Miss, clear=0: allocate a way.
  - Choose the lowest invalid way if one exists; otherwise the way at the set's pointer, and the pointer advances mod NR_WAYS.
  - The pointer advances only on eviction of a valid way.
  - The new entry writes tag, target and is_lower_16.
  - Initial counter = 2^(CNT_BITS-1) if taken (weakly taken), else 2^(CNT_BITS-1)-1.

Flush FSM (IDLE, FLUSH):
- IDLE with flush_i=1 at an edge: go to FLUSH, sweep pointer=0, and the same-cycle update is dropped.
- FLUSH: each edge clears valid, counter and round-robin pointer of set[ptr], then ptr+1.
  - The edge that clears set NR_SETS-1 returns to IDLE.
  - busy_o is high for exactly NR_SETS cycles.
- flush_i during FLUSH restarts the sweep at set 0.
- update_valid_i during FLUSH is dropped.

Reset:
- All entries are invalid, counters and pointers are 0, state=IDLE.
- busy_o=0 and all lookup outputs are 0.
- Reset during FLUSH aborts the sweep immediately.

Test Plan:
Default parameters apply: index=pc[6:1], tag=pc[14:7].
1. After reset, lookup 0x1000 -> lookup_valid_o=0, target=0, busy_o=0.
2. Update pc=0x1000 taken target=0x2000 -> next cycle lookup 0x1000: valid=1, taken=1, target=0x2000 (counter=2). Then update not-taken -> taken=0 (counter=1).
3. Install 0x1000 then 0x1080 (same set, different tag) -> both hit. Install 0x1100 -> way0 evicted, 0x1000 misses, 0x1080 and 0x1100 hit. Install 0x1180 -> way1 (0x1080) evicted.
4. Saturation: 3 taken updates from a new taken entry -> counter=3. A further taken update keeps counter=3. One not-taken update -> counter=2, taken stays 1.
5. Clear: update_clear on 0x1080 -> miss next cycle, 0x1100 unaffected. Clear on an absent PC (0x3000) -> no state change. Simultaneous lookup and update on the same PC -> old value returned that cycle.
6. Flush: pulse flush_i -> busy_o=1 for exactly 64 cycles with lookups missing; an update at cycle 10 of the sweep is dropped; afterwards all prior PCs miss. Second run: assert rst_ni=0 at sweep cycle 20 -> busy_o=0 immediately.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-set round-robin replacement
// and a one-set-per-cycle flush sweep. Lookup is combinational; updates land on the next edge.
module btb_assoc #(
    parameter int NR_SETS  = 64,
    parameter int NR_WAYS  = 2,
    parameter int CNT_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int VLEN     = 64,
    parameter int OFFSET   = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    output logic            busy_o,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            lookup_valid_o,
    output logic            lookup_taken_o,
    output logic [VLEN-1:0] lookup_target_o,
    output logic            lookup_is_lower_16_o,
    input  logic            update_valid_i,
    input  logic [VLEN-1:0] update_pc_i,
    input  logic [VLEN-1:0] update_target_i,
    input  logic            update_taken_i,
    input  logic            update_is_lower_16_i,
    input  logic            update_clear_i
);

    localparam int IDX_BITS = $clog2(NR_SETS);
    localparam int PTR_W    = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e              state_q;
    logic [IDX_BITS-1:0] flush_ptr_q;

    logic                valid_q  [NR_SETS][NR_WAYS];
    logic [CNT_BITS-1:0] cnt_q    [NR_SETS][NR_WAYS];
    logic [TAG_BITS-1:0] tag_q    [NR_SETS][NR_WAYS];
    logic [VLEN-1:0]     target_q [NR_SETS][NR_WAYS];
    logic                lower_q  [NR_SETS][NR_WAYS];
    logic [PTR_W-1:0]    rr_q     [NR_SETS];

    logic [IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, up_hit, up_inv_any;
    logic [PTR_W-1:0]    lk_way, up_hit_way, up_inv_way, wr_way;
    logic                upd_en, wr_data;
    logic [CNT_BITS-1:0] cnt_cur, cnt_nxt;
    logic                unused_pc_bits;

    assign lk_idx = lookup_pc_i[OFFSET +: IDX_BITS];
    assign lk_tag = lookup_pc_i[OFFSET + IDX_BITS +: TAG_BITS];
    assign up_idx = update_pc_i[OFFSET +: IDX_BITS];
    assign up_tag = update_pc_i[OFFSET + IDX_BITS +: TAG_BITS];
    assign unused_pc_bits = ^{lookup_pc_i, update_pc_i};

    // Ways are scanned from the top down so the lowest matching way wins.
    always_comb begin
        lk_hit     = 1'b0;
        lk_way     = '0;
        up_hit     = 1'b0;
        up_hit_way = '0;
        up_inv_any = 1'b0;
        up_inv_way = '0;
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = PTR_W'(w);
            end
            if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                up_hit     = 1'b1;
                up_hit_way = PTR_W'(w);
            end
            if (!valid_q[up_idx][w]) begin
                up_inv_any = 1'b1;
                up_inv_way = PTR_W'(w);
            end
        end
    end

    assign busy_o               = (state_q == FLUSH);
    assign lookup_valid_o       = lk_hit && !busy_o;
    assign lookup_taken_o       = lookup_valid_o && cnt_q[lk_idx][lk_way][CNT_BITS-1];
    assign lookup_target_o      = lookup_valid_o ? target_q[lk_idx][lk_way] : '0;
    assign lookup_is_lower_16_o = lookup_valid_o && lower_q[lk_idx][lk_way];

    assign upd_en  = (state_q == IDLE) && !flush_i && update_valid_i;
    assign wr_data = upd_en && !update_clear_i;
    assign wr_way  = up_hit ? up_hit_way : (up_inv_any ? up_inv_way : rr_q[up_idx]);
    assign cnt_cur = cnt_q[up_idx][up_hit_way];

    always_comb begin
        cnt_nxt = cnt_cur;
        if (update_taken_i) begin
            if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_BITS'(1);
        end else begin
            if (cnt_cur != '0) cnt_nxt = cnt_cur - CNT_BITS'(1);
        end
    end

    // Payload fields need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (wr_data) begin
            tag_q[up_idx][wr_way]    <= up_tag;
            target_q[up_idx][wr_way] <= update_target_i;
            lower_q[up_idx][wr_way]  <= update_is_lower_16_i;
        end
    end

    // Flush FSM plus valid/counter/pointer state, which the sweep must clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            flush_ptr_q <= '0;
            for (int s = 0; s < NR_SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < NR_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    cnt_q[s][w]   <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_q     <= FLUSH;
                        flush_ptr_q <= '0;
                    end else if (upd_en) begin
                        if (up_hit) begin
                            if (update_clear_i) valid_q[up_idx][up_hit_way] <= 1'b0;
                            else                cnt_q[up_idx][up_hit_way]   <= cnt_nxt;
                        end else if (!update_clear_i) begin
                            valid_q[up_idx][wr_way] <= 1'b1;
                            cnt_q[up_idx][wr_way]   <= update_taken_i ? CNT_WT : CNT_WNT;
                            if (!up_inv_any && NR_WAYS > 1) rr_q[up_idx] <= rr_q[up_idx] + PTR_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_i) begin
                        flush_ptr_q <= '0;
                    end else begin
                        rr_q[flush_ptr_q] <= '0;
                        for (int w = 0; w < NR_WAYS; w++) begin
                            valid_q[flush_ptr_q][w] <= 1'b0;
                            cnt_q[flush_ptr_q][w]   <= '0;
                        end
                        if (flush_ptr_q == IDX_BITS'(NR_SETS - 1)) state_q <= IDLE;
                        else flush_ptr_q <= flush_ptr_q + IDX_BITS'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc with default parameters
// (index = pc[6:1], tag = pc[14:7]).
module tb_btb_assoc;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        busy_o;
    logic [63:0] lookup_pc_i;
    logic        lookup_valid_o;
    logic        lookup_taken_o;
    logic [63:0] lookup_target_o;
    logic        lookup_is_lower_16_o;
    logic        update_valid_i;
    logic [63:0] update_pc_i;
    logic [63:0] update_target_i;
    logic        update_taken_i;
    logic        update_is_lower_16_i;
    logic        update_clear_i;

    int vectors     = 0;
    int miscompares = 0;
    int busy_cycles;

    btb_assoc dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .busy_o              (busy_o),
        .lookup_pc_i         (lookup_pc_i),
        .lookup_valid_o      (lookup_valid_o),
        .lookup_taken_o      (lookup_taken_o),
        .lookup_target_o     (lookup_target_o),
        .lookup_is_lower_16_o(lookup_is_lower_16_o),
        .update_valid_i      (update_valid_i),
        .update_pc_i         (update_pc_i),
        .update_target_i     (update_target_i),
        .update_taken_i      (update_taken_i),
        .update_is_lower_16_i(update_is_lower_16_i),
        .update_clear_i      (update_clear_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One resolved-branch update, committed at the next rising edge.
    task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] tgt,
                                 input logic taken, input logic lower, input logic clr);
        update_valid_i       = 1'b1;
        update_pc_i          = pc;
        update_target_i      = tgt;
        update_taken_i       = taken;
        update_is_lower_16_i = lower;
        update_clear_i       = clr;
        tick();
        update_valid_i = 1'b0;
        update_clear_i = 1'b0;
    endtask

    task automatic lookupCheck(input string tag, input logic [63:0] pc, input logic v,
                               input logic t, input logic [63:0] tgt);
        lookup_pc_i = pc;
        #1;
        checkOutput({tag, "_valid"}, 64'(lookup_valid_o), 64'(v));
        if (v) begin
            checkOutput({tag, "_taken"}, 64'(lookup_taken_o), 64'(t));
            checkOutput({tag, "_target"}, lookup_target_o, tgt);
        end else begin
            checkOutput({tag, "_target0"}, lookup_target_o, 64'h0);
        end
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; lookup_pc_i = 64'h1000;
        update_valid_i = 1'b0; update_pc_i = '0; update_target_i = '0;
        update_taken_i = 1'b0; update_is_lower_16_i = 1'b0; update_clear_i = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_busy", 64'(busy_o), 64'h0);
        lookupCheck("rst_lk", 64'h1000, 1'b0, 1'b0, 64'h0);

        $display("[TB] allocate and train");
        applyStimulus(64'h1000, 64'h2000, 1'b1, 1'b0, 1'b0);
        lookupCheck("alloc_t", 64'h1000, 1'b1, 1'b1, 64'h2000);
        applyStimulus(64'h1000, 64'h2000, 1'b0, 1'b0, 1'b0);
        lookupCheck("dec_nt", 64'h1000, 1'b1, 1'b0, 64'h2000);

        $display("[TB] replacement in set 0");
        applyStimulus(64'h1080, 64'h3080, 1'b1, 1'b0, 1'b0);
        lookupCheck("two_a", 64'h1000, 1'b1, 1'b0, 64'h2000);
        lookupCheck("two_b", 64'h1080, 1'b1, 1'b1, 64'h3080);
        applyStimulus(64'h1100, 64'h3100, 1'b1, 1'b1, 1'b0);
        lookupCheck("ev0_old", 64'h1000, 1'b0, 1'b0, 64'h0);
        lookupCheck("ev0_keep", 64'h1080, 1'b1, 1'b1, 64'h3080);
        lookupCheck("ev0_new", 64'h1100, 1'b1, 1'b1, 64'h3100);
        checkOutput("ev0_lower", 64'(lookup_is_lower_16_o), 64'h1);
        applyStimulus(64'h1180, 64'h3180, 1'b0, 1'b0, 1'b0);
        lookupCheck("ev1_old", 64'h1080, 1'b0, 1'b0, 64'h0);
        lookupCheck("ev1_new", 64'h1180, 1'b1, 1'b0, 64'h3180);
        lookupCheck("ev1_keep", 64'h1100, 1'b1, 1'b1, 64'h3100);

        $display("[TB] counter saturation");
        applyStimulus(64'h2004, 64'h7000, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(64'h2004, 64'h7000, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'h2004, 64'h7000, 1'b0, 1'b0, 1'b0);
        lookupCheck("sat_hi", 64'h2004, 1'b1, 1'b1, 64'h7000);
        applyStimulus(64'h2004, 64'h7004, 1'b0, 1'b0, 1'b0);
        lookupCheck("sat_hi2", 64'h2004, 1'b1, 1'b0, 64'h7004);
        applyStimulus(64'h2008, 64'h7100, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(64'h2008, 64'h7100, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'h2008, 64'h7100, 1'b1, 1'b0, 1'b0);
        lookupCheck("sat_lo", 64'h2008, 1'b1, 1'b0, 64'h7100);
        applyStimulus(64'h2008, 64'h7100, 1'b1, 1'b0, 1'b0);
        lookupCheck("sat_lo2", 64'h2008, 1'b1, 1'b1, 64'h7100);

        $display("[TB] clear and invalid-way preference");
        applyStimulus(64'h1180, 64'h0, 1'b0, 1'b0, 1'b1);
        lookupCheck("clr_gone", 64'h1180, 1'b0, 1'b0, 64'h0);
        lookupCheck("clr_keep", 64'h1100, 1'b1, 1'b1, 64'h3100);
        applyStimulus(64'h3000, 64'h0, 1'b0, 1'b0, 1'b1);
        lookupCheck("clr_absent", 64'h1100, 1'b1, 1'b1, 64'h3100);
        applyStimulus(64'h1080, 64'h3080, 1'b1, 1'b0, 1'b0);
        lookupCheck("fill_inv_keep", 64'h1100, 1'b1, 1'b1, 64'h3100);
        lookupCheck("fill_inv_new", 64'h1080, 1'b1, 1'b1, 64'h3080);
        applyStimulus(64'h1000, 64'h4000, 1'b1, 1'b0, 1'b0);
        lookupCheck("rr_old", 64'h1100, 1'b0, 1'b0, 64'h0);
        lookupCheck("rr_keep", 64'h1080, 1'b1, 1'b1, 64'h3080);

        $display("[TB] same-cycle lookup and update");
        lookup_pc_i = 64'h1080;
        update_valid_i = 1'b1; update_pc_i = 64'h1080; update_target_i = 64'h5554;
        update_taken_i = 1'b1; update_is_lower_16_i = 1'b0; update_clear_i = 1'b0;
        #1;
        checkOutput("bypass_old", lookup_target_o, 64'h3080);
        tick();
        update_valid_i = 1'b0;
        lookupCheck("bypass_new", 64'h1080, 1'b1, 1'b1, 64'h5554);

        $display("[TB] flush sweep");
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        busy_cycles = 0;
        while (busy_o && busy_cycles < 200) begin
            if (busy_cycles == 0) begin
                lookup_pc_i = 64'h1080;
                #1;
                checkOutput("flush_lk_miss", 64'(lookup_valid_o), 64'h0);
            end
            if (busy_cycles == 10) begin
                update_valid_i = 1'b1; update_pc_i = 64'h2010; update_target_i = 64'h9000;
                update_taken_i = 1'b1; update_clear_i = 1'b0;
            end
            if (busy_cycles == 11) update_valid_i = 1'b0;
            tick();
            busy_cycles++;
        end
        update_valid_i = 1'b0;
        checkOutput("flush_busy_len", 64'(busy_cycles), 64'd64);
        lookupCheck("post_flush_a", 64'h1080, 1'b0, 1'b0, 64'h0);
        lookupCheck("post_flush_b", 64'h2004, 1'b0, 1'b0, 64'h0);
        lookupCheck("post_flush_drop", 64'h2010, 1'b0, 1'b0, 64'h0);
        applyStimulus(64'h1000, 64'h4000, 1'b0, 1'b0, 1'b0);
        lookupCheck("post_flush_alloc", 64'h1000, 1'b1, 1'b0, 64'h4000);

        $display("[TB] reset during flush");
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (20) tick();
        checkOutput("pre_rst_busy", 64'(busy_o), 64'h1);
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_abort_busy", 64'(busy_o), 64'h0);
        lookupCheck("rst_abort_lk", 64'h1000, 1'b0, 1'b0, 64'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        checkOutput("after_rst_busy", 64'(busy_o), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
